icache_tag_nway: RTL

//  Parametrised N-way set-associative instruction-cache tag/valid array with tree-PLRU replacement.

---
 rtl/icache_tag_nway.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/icache_tag_nway.sv
// N-way I-cache tag/valid array with tree-PLRU replacement, refill FSM and fence.i invalidate sweep.
// Lookup is combinational in IDLE; a miss, refill or sweep holds stallreq through busy.
// Refill requests are held until the bus engine reports completion; a flush cannot cancel one.
module icache_tag_nway #(
    parameter int ADDR_W   = 64,
    parameter int WAYS     = 4,
    parameter int SETS     = 64,
    parameter int OFFSET_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              cacheable,
    input  logic              flush,
    input  logic              inval_req,
    input  logic              refill_done,
    output logic              hit,
    output logic [WAYS-1:0]   hit_way,
    output logic              miss,
    output logic              stallreq,
    output logic              refill_req,
    output logic [ADDR_W-1:0] refill_addr,
    output logic [WAYS-1:0]   victim_way,
    output logic              busy
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;
    localparam int LVL   = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, MISS, FILL, INVAL} state_t;
    state_t state, state_nxt;

    logic [TAG_W-1:0] tag_mem [WAYS][SETS];
    logic [WAYS-1:0]  valid [SETS];
    logic [WAYS-2:0]  plru [SETS];

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [OFFSET_W-1:0] unused_offset;
    logic                lookup_en;
    logic [WAYS-1:0]     hit_raw, hit_sel;
    logic [LVL-1:0]      hit_idx, vic_idx;
    logic                hit_found, vic_found;

    logic                pend_inval;
    logic [IDX_W-1:0]    inv_cnt;
    logic [TAG_W-1:0]    lat_tag;
    logic [IDX_W-1:0]    lat_idx;
    logic [LVL-1:0]      lat_vic_idx;
    logic [WAYS-1:0]     lat_vic;

    // Tree bits point toward the side to evict next; node n has children 2n+1 and 2n+2.
    function automatic logic [LVL-1:0] plru_pick(input logic [WAYS-2:0] bits);
        int             node;
        logic [LVL-1:0] way;
        node = 0;
        way  = '0;
        for (int l = 0; l < LVL; l++) begin
            way  = LVL'({way, bits[node]});
            node = 2 * node + 1 + int'(bits[node]);
        end
        return way;
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [LVL-1:0]  way);
        int               node;
        logic             dir;
        logic [WAYS-2:0]  res;
        node = 0;
        res  = bits;
        for (int l = 0; l < LVL; l++) begin
            dir       = way[LVL-1-l];
            res[node] = ~dir;
            node      = 2 * node + 1 + int'(dir);
        end
        return res;
    endfunction

    assign req_tag       = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx       = req_addr[OFFSET_W +: IDX_W];
    assign unused_offset = req_addr[OFFSET_W-1:0];

    always_comb begin
        hit_raw   = '0;
        hit_sel   = '0;
        hit_idx   = '0;
        hit_found = 1'b0;
        for (int w = 0; w < WAYS; w++)
            hit_raw[w] = valid[req_idx][w] && (tag_mem[w][req_idx] == req_tag);
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_found && hit_raw[w]) begin
                hit_sel[w] = 1'b1;
                hit_idx    = LVL'(w);
                hit_found  = 1'b1;
            end
        end
    end

    // Invalid ways are filled lowest-first before the PLRU tree is consulted.
    always_comb begin
        vic_idx   = plru_pick(plru[req_idx]);
        vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid[req_idx][w]) begin
                vic_idx   = LVL'(w);
                vic_found = 1'b1;
            end
        end
    end

    assign lookup_en   = (state == IDLE) && req_valid && cacheable && !flush && !inval_req;
    assign hit         = lookup_en && (|hit_raw);
    assign hit_way     = lookup_en ? hit_sel : '0;
    assign miss        = lookup_en && !(|hit_raw);
    assign busy        = (state != IDLE);
    assign stallreq    = miss || (req_valid && !cacheable) || busy;
    assign refill_req  = (state == MISS);
    assign refill_addr = {lat_tag, lat_idx, {OFFSET_W{1'b0}}};
    assign victim_way  = lat_vic;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (inval_req) state_nxt = INVAL;
                     else if (miss) state_nxt = MISS;
            MISS:    if (refill_done) state_nxt = FILL;
            FILL:    state_nxt = (pend_inval || inval_req) ? INVAL : IDLE;
            INVAL:   if (inv_cnt == IDX_W'(SETS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pend_inval  <= 1'b0;
            inv_cnt     <= '0;
            lat_tag     <= '0;
            lat_idx     <= '0;
            lat_vic_idx <= '0;
            lat_vic     <= '0;
        end else begin
            state <= state_nxt;
            if (miss) begin
                lat_tag     <= req_tag;
                lat_idx     <= req_idx;
                lat_vic_idx <= vic_idx;
                lat_vic     <= WAYS'(1) << vic_idx;
            end
            if ((state == MISS || state == FILL) && inval_req)
                pend_inval <= 1'b1;
            else if (state == INVAL)
                pend_inval <= 1'b0;
            if (state == INVAL)
                inv_cnt <= inv_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                plru[s]  <= '0;
            end
        end else begin
            case (state)
                IDLE: if (hit) plru[req_idx] <= plru_touch(plru[req_idx], hit_idx);
                FILL: begin
                    valid[lat_idx][lat_vic_idx] <= 1'b1;
                    plru[lat_idx]               <= plru_touch(plru[lat_idx], lat_vic_idx);
                end
                INVAL: begin
                    valid[inv_cnt] <= '0;
                    plru[inv_cnt]  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Tag storage needs no reset: a line is only trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (state == FILL)
            tag_mem[lat_vic_idx][lat_idx] <= lat_tag;
    end

    always_ff @(posedge clk) begin
        if (lookup_en)
            assert ($onehot0(hit_raw));
    end
endmodule
